// File: rtl/siphash_msg_sequencer_pkg.sv
// Shared widths, FSM state encoding and padding constants for the SipHash message sequencer.
package siphash_msg_sequencer_pkg;

   localparam int unsigned BYTE_W       = 8;
   localparam int unsigned WORD_W       = 64;
   localparam int unsigned KEY_W        = 128;
   localparam int unsigned BYTE_CTR_W   = 3;
   localparam int unsigned LEN_W        = 8;
   localparam int unsigned RND_W        = 4;
   localparam int unsigned STATE_W      = 4;
   // Byte lane of the final word that carries the message length.
   localparam int unsigned PAD_BYTE_POS = 7;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 4'd0,
      ST_INIT    = 4'd1,
      ST_COLLECT = 4'd2,
      ST_COMP    = 4'd3,
      ST_CWAIT1  = 4'd4,
      ST_CWAIT   = 4'd5,
      ST_PAD     = 4'd6,
      ST_FIN     = 4'd7,
      ST_FWAIT1  = 4'd8,
      ST_FWAIT   = 4'd9,
      ST_OUT     = 4'd10
   } state_t;

endpackage

// File: rtl/siphash_msg_sequencer_if.sv
// Message byte stream in, 64-bit tag out.
interface siphash_msg_sequencer_if;

   logic [siphash_msg_sequencer_pkg::BYTE_W-1:0] s_data;
   logic                                         s_valid;
   logic                                         s_last;
   logic                                         s_ready;
   logic [siphash_msg_sequencer_pkg::WORD_W-1:0] hash;
   logic                                         hash_valid;
   logic                                         hash_ready;

   // Message source / tag consumer side.
   modport master (
      output s_data, s_valid, s_last, hash_ready,
      input  s_ready, hash, hash_valid
   );

   // Sequencer side.
   modport slave (
      input  s_data, s_valid, s_last, hash_ready,
      output s_ready, hash, hash_valid
   );

endinterface

// File: rtl/siphash_msg_sequencer_word_packer.sv
// Little-endian byte-to-word packer with SipHash length padding.
module siphash_msg_sequencer_word_packer
   import siphash_msg_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic              pad,
   input  logic [BYTE_W-1:0] data,
   output logic [WORD_W-1:0] word,
   output logic              full
);

   logic [BYTE_CTR_W-1:0] byte_ctr;
   logic [LEN_W-1:0]      len_ctr;
   logic                  padded;

   // Buffer, counters and pad insertion; a clear after padding also rewinds the counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         word     <= '0;
         full     <= 1'b0;
         byte_ctr <= '0;
         len_ctr  <= '0;
         padded   <= 1'b0;
      end else if (clear) begin
         word <= '0;
         if (padded) begin
            byte_ctr <= '0;
            len_ctr  <= '0;
            full     <= 1'b0;
            padded   <= 1'b0;
         end
      end else if (pad) begin
         word[PAD_BYTE_POS*BYTE_W +: BYTE_W] <= len_ctr;
         padded                              <= 1'b1;
      end else if (load) begin
         word[{byte_ctr, 3'b000} +: BYTE_W] <= data;
         byte_ctr <= byte_ctr + BYTE_CTR_W'(1);
         len_ctr  <= len_ctr + LEN_W'(1);
         full     <= (byte_ctr == BYTE_CTR_W'(PAD_BYTE_POS - 1));
      end
   end

endmodule

// File: rtl/siphash_msg_sequencer.sv
// Drives siphash_core commands from a byte stream and returns the tag.
module siphash_msg_sequencer
   import siphash_msg_sequencer_pkg::*;
#(
   parameter int unsigned C_ROUNDS = 2,
   parameter int unsigned D_ROUNDS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   empty,
   input  logic [KEY_W-1:0]       key,
   output logic                   busy,
   siphash_msg_sequencer_if.slave msg,
   output logic                   core_initalize,
   output logic                   core_compress,
   output logic                   core_finalize,
   output logic [RND_W-1:0]       core_c,
   output logic [RND_W-1:0]       core_d,
   output logic [KEY_W-1:0]       core_k,
   output logic [WORD_W-1:0]      core_mi,
   input  logic                   core_ready,
   input  logic [WORD_W-1:0]      core_word,
   input  logic                   core_word_valid
);

   state_t state, state_nx;
   logic   empty_q, last_flag, pad_flag;
   logic   accept, pk_load, pk_clear, pk_pad, pk_full, key_latch, hash_capture;

   assign core_c = RND_W'(C_ROUNDS);
   assign core_d = RND_W'(D_ROUNDS);

   siphash_msg_sequencer_word_packer u_packer (
      .clk   (clk),
      .reset (reset),
      .load  (pk_load),
      .clear (pk_clear),
      .pad   (pk_pad),
      .data  (msg.s_data),
      .word  (core_mi),
      .full  (pk_full)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   // Next-state and packer/latch strobes.
   always_comb begin
      state_nx     = state;
      accept       = 1'b0;
      pk_load      = 1'b0;
      pk_clear     = 1'b0;
      pk_pad       = 1'b0;
      key_latch    = 1'b0;
      hash_capture = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               key_latch = 1'b1;
               pk_clear  = 1'b1;
               state_nx  = ST_INIT;
            end
         end
         ST_INIT:    state_nx = empty_q ? ST_PAD : ST_COLLECT;
         ST_COLLECT: begin
            accept = msg.s_valid & msg.s_ready;
            if (accept) begin
               pk_load = 1'b1;
               if (pk_full)         state_nx = ST_COMP;
               else if (msg.s_last) state_nx = ST_PAD;
            end
         end
         ST_COMP:   state_nx = ST_CWAIT1;
         ST_CWAIT1: state_nx = ST_CWAIT;
         ST_CWAIT: begin
            if (core_ready) begin
               pk_clear = 1'b1;
               if (pad_flag)       state_nx = ST_FIN;
               else if (last_flag) state_nx = ST_PAD;
               else                state_nx = ST_COLLECT;
            end
         end
         ST_PAD: begin
            pk_pad   = 1'b1;
            state_nx = ST_COMP;
         end
         ST_FIN:    state_nx = ST_FWAIT1;
         ST_FWAIT1: state_nx = ST_FWAIT;
         ST_FWAIT: begin
            if (core_word_valid && core_ready) begin
               hash_capture = 1'b1;
               state_nx     = ST_OUT;
            end
         end
         ST_OUT: begin
            if (msg.hash_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Registered outputs decoded from the next state, plus message-level flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy           <= 1'b0;
         msg.s_ready    <= 1'b0;
         msg.hash_valid <= 1'b0;
         msg.hash       <= '0;
         core_initalize <= 1'b0;
         core_compress  <= 1'b0;
         core_finalize  <= 1'b0;
         core_k         <= '0;
         empty_q        <= 1'b0;
         last_flag      <= 1'b0;
         pad_flag       <= 1'b0;
      end else begin
         busy           <= (state_nx != ST_IDLE);
         msg.s_ready    <= (state_nx == ST_COLLECT);
         msg.hash_valid <= (state_nx == ST_OUT);
         core_initalize <= (state_nx == ST_INIT);
         core_compress  <= (state_nx == ST_COMP);
         core_finalize  <= (state_nx == ST_FIN);
         if (key_latch) begin
            core_k    <= key;
            empty_q   <= empty;
            last_flag <= 1'b0;
            pad_flag  <= 1'b0;
         end
         if (accept && pk_full) last_flag <= msg.s_last;
         if (pk_pad)            pad_flag  <= 1'b1;
         if (hash_capture)      msg.hash  <= core_word;
      end
   end

endmodule
